id_ex_stage: RTL
================

# id_ex_stage

Decode/execute pipeline register for the 16-bit pipelined core. It captures operands read from the register file with the decoded instruction fields and presents them to the execute stage one cycle later. It detects load-use hazards and inserts bubbles. It also honours a downstream hold and a branch flush, and drives the stall back to fetch/decode.

## Interface
Parameters: none.

Clock and reset:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset

Decode-side inputs:
- id_valid  in  1  decode holds a real instruction
- id_pc  in  16  instruction PC
- id_opcode  in  4  opcode
- id_src1, id_src2, id_dst  in  4 each  register IDs
- id_uses_src1, id_uses_src2  in  1 each  operand actually read
- id_data1, id_data2  in  16 each  operand values from the register file read ports
- id_imm  in  16  sign/zero-extended immediate
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits

Control inputs:
- flush  in  1  branch mispredict/taken; kill the instruction entering EX
- ex_hold  in  1  downstream busy; freeze EX contents

Outputs:
- id_stall  out  1  decode and fetch must hold PC and instruction this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_opcode, ex_src1, ex_src2, ex_dst, ex_data1, ex_data2, ex_imm  out  registered copies of the id_* fields (same widths)
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered control bits, qualified by valid

## Operation
- load_use = LOADUSE_EN && ex_valid && ex_mem_read && ex_dst!=0 && id_valid && ((id_uses_src1 && id_src1==ex_dst) || (id_uses_src2 && id_src2==ex_dst)).
- id_stall = !flush && (ex_hold || load_use). It is combinational from registered EX state and the current inputs.
- Next-state priority, highest first:
  1. rst low: every ex_* output is 0.
  2. flush: bubble. ex_valid and all three control bits become 0; payload fields retain their values. flush overrides ex_hold.
  3. ex_hold: all EX registers hold.
  4. load_use: bubble, same as flush.
  5. Otherwise capture:
     - ex_valid <= id_valid.
     - Payload fields <= id_*.
     - ex_mem_read <= id_mem_read & id_valid; ex_mem_write likewise.
     - ex_reg_write <= id_reg_write & id_valid & (id_dst!=0). R0 is never written.
- Invariant: ex_valid==0 implies all three ex control bits are 0.
- Register ID 0 never triggers load_use. R0 is hardwired to zero.
- Operand data is captured as presented. The register file already bypasses same-cycle writeback, so this block adds no forwarding.

## Timing
- Latency: ID to EX is exactly 1 cycle.
- A load-use stall lasts exactly 1 cycle. After the bubble enters, ex_mem_read is 0, load_use deasserts, and the held instruction is captured on the next edge.
- load_use during ex_hold: hold wins and id_stall stays 1. The hazard is re-evaluated once the hold is released.
- flush and load_use together: bubble, id_stall=0. The upstream instruction is wrong-path and is discarded by fetch.
- Reset asserted mid-stream: outputs go to 0 immediately, without waiting for a clock. The first capture occurs on the first rising edge after rst rises.

## Configuration
- LOADUSE_EN defined: load-use detection and bubble insertion are active as described.
- LOADUSE_EN undefined: load_use is the constant 0 and id_stall = !flush && ex_hold. The hazard logic is not synthesised, so software scheduling must avoid load-use pairs.

## Test plan
- Reset: drive rst=0 mid-cycle with ex_valid=1 -> all ex_* outputs read 0 immediately and id_stall=0. After rst=1, the next edge captures id_pc=0x0010.
- Plain capture: id_valid=1, id_dst=3, id_reg_write=1, id_data1=0xBEEF, id_imm=0x0004 -> the next cycle shows ex_valid=1, ex_dst=3, ex_reg_write=1, ex_data1=0xBEEF, ex_imm=0x0004.
- R0 write suppression: id_dst=0, id_reg_write=1, id_valid=1 -> ex_reg_write=0 and ex_valid=1.
- Load-use (LOADUSE_EN defined): EX holds a load with ex_dst=5; ID holds id_src2=5 with id_uses_src2=1.
  - id_stall=1 for exactly 1 cycle and EX becomes a bubble (ex_valid=0).
  - The following edge captures the ID instruction.
  - With id_uses_src2=0 there is no stall.
  - With the macro undefined there is never a stall.
- Hold then flush: ex_hold=1 for 3 cycles -> EX contents are unchanged and id_stall=1 throughout. Asserting flush together with ex_hold=1 -> next cycle ex_valid=0, all controls 0, id_stall=0.
- Flush vs. load-use: flush=1 while the load-use condition is true -> bubble inserted, id_stall=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode/execute pipeline register for the 16-bit core.
// Captures register-file operands and decoded fields for the execute stage,
// inserts bubbles on load-use hazards and branch flushes, and honours a
// downstream hold.
// Optional feature macro: LOADUSE_EN enables load-use hazard detection.
// Without it the hazard logic is absent and the stall comes only from ex_hold.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [15:0] id_pc,
   input  logic [3:0]  id_opcode,
   input  logic [3:0]  id_src1,
   input  logic [3:0]  id_src2,
   input  logic [3:0]  id_dst,
   input  logic        id_uses_src1,
   input  logic        id_uses_src2,
   input  logic [15:0] id_data1,
   input  logic [15:0] id_data2,
   input  logic [15:0] id_imm,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic        flush,
   input  logic        ex_hold,
   output logic        id_stall,
   output logic        ex_valid,
   output logic [15:0] ex_pc,
   output logic [3:0]  ex_opcode,
   output logic [3:0]  ex_src1,
   output logic [3:0]  ex_src2,
   output logic [3:0]  ex_dst,
   output logic [15:0] ex_data1,
   output logic [15:0] ex_data2,
   output logic [15:0] ex_imm,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write
);

   logic loadUse;
   logic insertBubble;

`ifdef LOADUSE_EN
   logic src1Hit;
   logic src2Hit;

   // A load in EX whose destination is read by the instruction in ID; R0 never hazards
   always_comb begin
      src1Hit = id_uses_src1 && (id_src1 == ex_dst);
      src2Hit = id_uses_src2 && (id_src2 == ex_dst);
      loadUse = ex_valid && ex_mem_read && (ex_dst != 4'd0) && id_valid
                && (src1Hit || src2Hit);
   end
`else
   assign loadUse = 1'b0;
`endif

   // A flush discards the upstream wrong-path instruction, so it never stalls
   assign id_stall     = !flush && (ex_hold || loadUse);
   assign insertBubble = flush || (!ex_hold && loadUse);

   // Validity and control bits: cleared on any bubble so the valid/control invariant holds
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
      end else if (insertBubble) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
      end else if (!ex_hold) begin
         ex_valid     <= id_valid;
         ex_reg_write <= id_reg_write && id_valid && (id_dst != 4'd0);
         ex_mem_read  <= id_mem_read && id_valid;
         ex_mem_write <= id_mem_write && id_valid;
      end
   end

   // Payload fields: loaded only on a real capture, retained through holds and bubbles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_pc     <= '0;
         ex_opcode <= '0;
         ex_src1   <= '0;
         ex_src2   <= '0;
         ex_dst    <= '0;
         ex_data1  <= '0;
         ex_data2  <= '0;
         ex_imm    <= '0;
      end else if (!insertBubble && !ex_hold) begin
         ex_pc     <= id_pc;
         ex_opcode <= id_opcode;
         ex_src1   <= id_src1;
         ex_src2   <= id_src2;
         ex_dst    <= id_dst;
         ex_data1  <= id_data1;
         ex_data2  <= id_data2;
         ex_imm    <= id_imm;
      end
   end

endmodule
